// File: rtl/decoder.sv
// Instruction decoder: condition check, addressing-mode resolution of the B operand and
// handshake with the execute stage.
module decoder #(
  parameter int unsigned RF_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_instruction,
  input  logic [31:0] i_immediate,
  input  logic [3:0]  i_rb_idx,
  input  logic        i_valid,
  input  logic [3:0]  i_flags,
  output logic [3:0]  o_rf_addr,
  output logic        o_rf_re,
  input  logic [31:0] i_rf_dat,
  output logic [5:0]  o_op,
  output logic [3:0]  o_ra_idx,
  output logic [31:0] o_operand,
  output logic        o_exec,
  input  logic        i_ready,
  output logic        o_skip,
  output logic        o_illegal,
  output logic        o_overrun,
  output logic        o_busy
);

  if (RF_LATENCY != 1) begin : g_latency_check
    $error("decoder: RF_LATENCY must be 1");
  end

  typedef enum logic [1:0] {StIdle, StRfrd, StRfwait, StOut} state_e;

  state_e      state;
  logic [31:0] imm_q;

  logic [5:0] dec_op;
  logic [2:0] dec_cc;
  logic [3:0] dec_ra;
  logic [2:0] dec_am;
  logic       cond_true;

  assign dec_op = i_instruction[15:10];
  assign dec_cc = i_instruction[9:7];
  assign dec_ra = i_instruction[6:3];
  assign dec_am = i_instruction[2:0];

  // Flags are ordered {V,N,C,Z}.
  always_comb begin
    cond_true = 1'b1;
    unique case (dec_cc)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = i_flags[0];
      3'b010: cond_true = ~i_flags[0];
      3'b011: cond_true = i_flags[1];
      3'b100: cond_true = ~i_flags[1];
      3'b101: cond_true = i_flags[2];
      3'b110: cond_true = ~i_flags[2];
      3'b111: cond_true = i_flags[3];
      default: cond_true = 1'b1;
    endcase
  end

  assign o_busy = (state != StIdle);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= StIdle;
      imm_q     <= '0;
      o_rf_addr <= '0;
      o_rf_re   <= 1'b0;
      o_op      <= '0;
      o_ra_idx  <= '0;
      o_operand <= '0;
      o_exec    <= 1'b0;
      o_skip    <= 1'b0;
      o_illegal <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_skip    <= 1'b0;
      o_illegal <= 1'b0;
      o_overrun <= 1'b0;
      o_rf_re   <= 1'b0;
      if (i_valid && state != StIdle) begin
        o_overrun <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (i_valid) begin
            o_op     <= dec_op;
            o_ra_idx <= dec_ra;
            imm_q    <= i_immediate;
            if (dec_am[2]) begin
              o_illegal <= 1'b1;
            end else if (!cond_true) begin
              o_skip <= 1'b1;
            end else begin
              case (dec_am[1:0])
                2'b00: begin
                  o_operand <= '0;
                  o_exec    <= 1'b1;
                  state     <= StOut;
                end
                2'b11: begin
                  o_operand <= i_immediate;
                  o_exec    <= 1'b1;
                  state     <= StOut;
                end
                default: begin
                  // Strobe is raised on entry so it is visible for the whole RFRD cycle.
                  o_rf_re   <= 1'b1;
                  o_rf_addr <= i_rb_idx;
                  state     <= StRfrd;
                end
              endcase
            end
          end
        end
        StRfrd: begin
          state <= StRfwait;
        end
        StRfwait: begin
          o_operand <= i_rf_dat + imm_q;
          o_exec    <= 1'b1;
          state     <= StOut;
        end
        StOut: begin
          if (i_ready) begin
            o_exec <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed scenarios plus randomized instructions against a
// behavioural model of condition, addressing mode and latency.
module tb_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_instruction;
  logic [31:0] i_immediate;
  logic [3:0]  i_rb_idx;
  logic        i_valid;
  logic [3:0]  i_flags;
  logic [3:0]  o_rf_addr;
  logic        o_rf_re;
  logic [31:0] i_rf_dat;
  logic [5:0]  o_op;
  logic [3:0]  o_ra_idx;
  logic [31:0] o_operand;
  logic        o_exec;
  logic        i_ready;
  logic        o_skip;
  logic        o_illegal;
  logic        o_overrun;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [16];

  decoder #(.RF_LATENCY(1)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_instruction(i_instruction),
    .i_immediate  (i_immediate),
    .i_rb_idx     (i_rb_idx),
    .i_valid      (i_valid),
    .i_flags      (i_flags),
    .o_rf_addr    (o_rf_addr),
    .o_rf_re      (o_rf_re),
    .i_rf_dat     (i_rf_dat),
    .o_op         (o_op),
    .o_ra_idx     (o_ra_idx),
    .o_operand    (o_operand),
    .o_exec       (o_exec),
    .i_ready      (i_ready),
    .o_skip       (o_skip),
    .o_illegal    (o_illegal),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Register file with one cycle of read latency.
  initial i_rf_dat = '0;
  always @(posedge i_clk) begin
    if (o_rf_re) i_rf_dat <= rf[o_rf_addr];
  end

  // Flags are {V,N,C,Z}.
  function automatic bit cond_ok(input logic [2:0] cc, input logic [3:0] fl);
    case (cc)
      3'd0: return 1'b1;
      3'd1: return fl[0];
      3'd2: return !fl[0];
      3'd3: return fl[1];
      3'd4: return !fl[1];
      3'd5: return fl[2];
      3'd6: return !fl[2];
      default: return fl[3];
    endcase
  endfunction

  // Issues one instruction at the current negedge and follows it to completion.
  // hold < 0: random i_ready; hold >= 0: i_ready low for the first hold exec cycles.
  // ovr_at > 0: a second i_valid is driven at that cycle offset.
  task automatic run_one(input string name, input logic [15:0] ins, input logic [31:0] imm,
                         input logic [3:0] rb, input logic [3:0] fl, input int hold,
                         input int ovr_at);
    int          kind;
    int          exp_lat;
    bit          exp_rf;
    logic [31:0] exp_operand;
    logic [5:0]  exp_st;
    logic [5:0]  got_st;
    int          k;
    int          exec_count;
    bit          done;
    bit          prev_exec;
    bit          prev_rdy;
    bit          rdy;
    bit          exp_ovr;

    kind = ins[2] ? 2 : (cond_ok(ins[9:7], fl) ? 0 : 1);
    exp_lat = (ins[1:0] == 2'd0 || ins[1:0] == 2'd3) ? 1 : 3;
    exp_rf = (kind == 0) && (exp_lat == 3);
    if (ins[1:0] == 2'd0) exp_operand = 32'd0;
    else if (ins[1:0] == 2'd3) exp_operand = imm;
    else exp_operand = rf[rb] + imm;

    i_instruction = ins;
    i_immediate   = imm;
    i_rb_idx      = rb;
    i_flags       = fl;
    i_valid       = 1'b1;
    i_ready       = (hold < 0) ? 1'($urandom % 2) : 1'b0;
    @(negedge i_clk);
    i_valid       = 1'b0;
    i_flags       = 4'($urandom);
    i_immediate   = $urandom;
    i_instruction = 16'($urandom);
    i_rb_idx      = 4'($urandom);

    k = 1; exec_count = 0; done = 0; prev_exec = 0; prev_rdy = 0;
    while (!done && k < 30) begin
      exp_ovr = (ovr_at > 0) && (k == ovr_at + 1);
      got_st  = {o_exec, o_busy, o_rf_re, o_skip, o_illegal, o_overrun};
      if (kind != 0) begin
        exp_st = {1'b0, 1'b0, 1'b0, (k == 1 && kind == 1), (k == 1 && kind == 2), exp_ovr};
        if (k == 3) done = 1;
      end else if (prev_exec && prev_rdy) begin
        exp_st = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ovr};
        done = 1;
      end else begin
        exp_st = {(k >= exp_lat), 1'b1, (exp_rf && k == 1), 1'b0, 1'b0, exp_ovr};
      end
      checks++;
      if (got_st !== exp_st) begin
        failures++;
        $display("FAIL %s status k=%0d {exec,busy,re,skip,ill,ovr} got %b want %b",
                 name, k, got_st, exp_st);
      end
      if (o_rf_re) begin
        checks++;
        if (o_rf_addr !== rb) begin
          failures++;
          $display("FAIL %s rf_addr got %0d want %0d", name, o_rf_addr, rb);
        end
      end
      if (o_exec && !done) begin
        exec_count++;
        checks++;
        if (o_op !== ins[15:10] || o_ra_idx !== ins[6:3] || o_operand !== exp_operand) begin
          failures++;
          $display("FAIL %s data k=%0d op/ra/operand got %h/%h/%h want %h/%h/%h", name, k,
                   o_op, o_ra_idx, o_operand, ins[15:10], ins[6:3], exp_operand);
        end
      end
      i_valid = (ovr_at > 0 && k == ovr_at);
      if (i_valid) begin
        i_instruction = 16'($urandom);
        i_immediate   = $urandom;
        i_rb_idx      = 4'($urandom);
      end
      if (hold < 0) rdy = 1'($urandom % 2);
      else rdy = o_exec && (exec_count > hold);
      prev_exec = o_exec;
      prev_rdy  = rdy;
      i_ready   = rdy;
      if (!done) begin
        @(negedge i_clk);
        k++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout waiting for completion", name);
    end
    if (kind == 0 && hold >= 0) begin
      checks++;
      if (exec_count != hold + 1) begin
        failures++;
        $display("FAIL %s exec_cycles got %0d want %0d", name, exec_count, hold + 1);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] st;
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_instruction = '0;
    i_immediate = '0; i_rb_idx = '0; i_flags = '0;
    #1;
    st = {o_exec, o_busy, o_rf_re, o_skip, o_illegal, o_overrun};
    checks++;
    if (st !== 6'b0 || o_op !== 6'd0 || o_ra_idx !== 4'd0 || o_rf_addr !== 4'd0 ||
        o_operand !== 32'd0) begin
      failures++;
      $display("FAIL reset_state ctl=%b op=%h ra=%h addr=%h operand=%h want all zero",
               st, o_op, o_ra_idx, o_rf_addr, o_operand);
    end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  task automatic test_basic();
    run_one("am000_basic", 16'h0400, 32'h1234_5678, 4'd3, 4'h0, 0, 0);
  endtask

  task automatic test_hold();
    run_one("am011_hold", 16'h0803, 32'hDEAD_BEEF, 4'd0, 4'h0, 3, 0);
  endtask

  task automatic test_rf_read();
    run_one("am001_rf", 16'h0C01, 32'hFFFF_FFFF, 4'd5, 4'h0, 0, 0);
    run_one("am010_rf_hold", 16'h1412, 32'h0000_0100, 4'd11, 4'h0, 2, 0);
  endtask

  task automatic test_skip_illegal();
    run_one("cc_z_skip", 16'h1081, 32'h1, 4'd1, 4'b0000, 0, 0);
    run_one("am100_illegal", 16'h1084, 32'h1, 4'd1, 4'b0000, 0, 0);
    run_one("cc_nz_taken", 16'h1103, 32'h55, 4'd1, 4'b0000, 0, 0);
  endtask

  task automatic test_overrun();
    run_one("overrun_rfwait", 16'h103A, 32'h0000_0100, 4'd9, 4'h0, 0, 2);
    run_one("overrun_out", 16'h2003, 32'hCAFE_0000, 4'd0, 4'h0, 2, 1);
  endtask

  task automatic test_reset_mid();
    logic [5:0] st;
    i_instruction = 16'h0803; i_immediate = 32'hA5A5_A5A5; i_valid = 1'b1; i_ready = 1'b0;
    i_flags = 4'h0; i_rb_idx = 4'd0;
    @(negedge i_clk);
    i_valid = 1'b0;
    checks++;
    if (o_exec !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid pre exec got %b want 1", o_exec);
    end
    #3 i_reset = 1'b0;
    #1;
    st = {o_exec, o_busy, o_rf_re, o_skip, o_illegal, o_overrun};
    checks++;
    if (st !== 6'b0 || o_operand !== 32'd0 || o_op !== 6'd0) begin
      failures++;
      $display("FAIL reset_mid async ctl=%b operand=%h op=%h want zero", st, o_operand, o_op);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    run_one("after_reset_skip", 16'h0C81, 32'h7, 4'd2, 4'b0001 ^ 4'b0001, 0, 0);
    run_one("after_reset_rf", 16'h0C01, 32'h0000_0001, 4'd5, 4'h0, -1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      run_one("random", 16'($urandom), $urandom, 4'($urandom), 4'($urandom), -1, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[5] = 32'h0000_0010;
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_hold();
    test_rf_read();
    test_skip_illegal();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
